// File: rtl/lab7_soc_led_pulse_pio.sv
// rtl/lab7_soc_led_pulse_pio.sv - Avalon-MM output PIO with bit set/clear and self-timed pulses
module lab7_soc_led_pulse_pio #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16,
  parameter int               LEN_RESET   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PULSING = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] pulse_mask;
  logic [WIDTH-1:0] wd;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] len_m1;
  logic             wr;
  logic             pulse_wr;
  logic [31:0]      rd_mux;

  assign wr       = chipselect & ~write_n;
  assign wd       = writedata[WIDTH-1:0];
  // A zero length behaves as one cycle, so the reload value is eff_len - 1.
  assign len_m1   = (pulse_len == '0) ? '0 : pulse_len - CNT_W'(1);
  assign pulse_wr = wr && (address == 3'd4) && (wd != '0);
  assign out_port = data | pulse_mask;

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[WIDTH-1:0] = data;
      3'd1:    rd_mux[CNT_W-1:0] = pulse_len;
      3'd4:    rd_mux[WIDTH-1:0] = pulse_mask;
      3'd5:    rd_mux[1:0]       = {pulse_len == '0, state == PULSING};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        3'd0:    data <= wd;
        3'd2:    data <= data | wd;
        3'd3:    data <= data & ~wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_len <= CNT_W'(LEN_RESET);
    end else if (wr && (address == 3'd1)) begin
      pulse_len <= writedata[CNT_W-1:0];
    end
  end

  // Retrigger outranks expiry, so a write on the count==0 cycle extends the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pulse_mask <= '0;
      count      <= '0;
    end else if (pulse_wr) begin
      pulse_mask <= (state == IDLE) ? wd : (pulse_mask | wd);
      count      <= len_m1;
      state      <= PULSING;
    end else if (state == PULSING) begin
      if (count != '0) begin
        count <= count - CNT_W'(1);
      end else begin
        pulse_mask <= '0;
        state      <= IDLE;
      end
    end
  end

endmodule

// File: doc/lab7_soc_led_pulse_pio.md
Name: lab7_soc_led_pulse_pio

Overview:
Avalon-MM slave output PIO. It is the write/drive-side counterpart of the system's input PIOs: the NIOS II writes registers, and the block drives `out_port`, for example to LEDs or a hex display.
Beyond a plain data register, it supports atomic bit set and bit clear, plus a self-timed pulse function. Pulsed bits go high for a programmable number of clocks and then clear in hardware, with no CPU involvement. The block sits on the SoC's Avalon fabric alongside the existing PIO slaves.

Parameters:
- WIDTH, 8, width of `out_port` and of the data/pulse registers (1..32)
- RESET_VALUE, 0, value of the DATA register after reset
- CNT_W, 16, width of the pulse-length register and counter
- LEN_RESET, 1, PULSE_LEN value after reset

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data; bits above WIDTH/CNT_W ignored
- readdata  out  32  registered read data
- out_port  out  WIDTH  driven output

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low on `reset_n`; every register is cleared/preset immediately on assertion.
- Reset values:
  - `data` = RESET_VALUE
  - `pulse_mask` = 0
  - `pulse_len` = LEN_RESET
  - `count` = 0
  - state = IDLE
  - `readdata` = 0
  - `out_port` = RESET_VALUE
- Write qualifier: `wr = chipselect & ~write_n`. A write takes effect at the rising edge where `wr` = 1.
- Register map (word address):
  - 0 DATA: R/W. `data <= writedata[WIDTH-1:0]`.
  - 1 PULSE_LEN: R/W. `pulse_len <= writedata[CNT_W-1:0]`.
  - 2 SET: W. `data <= data | wd`. Reads return 0.
  - 3 CLEAR: W. `data <= data & ~wd`. Reads return 0.
  - 4 PULSE: W. Starts or retriggers a pulse on the bits set in `wd`. Reads return the current `pulse_mask`.
  - 5 STATUS: R. bit0 = busy (state == PULSING); bit1 = 1 if `pulse_len` == 0. Other bits 0.
  - 6, 7: reads return 0; writes are ignored.
- Read path: `readdata` is registered every clock from the address mux, zero-extended to 32 bits, independent of `chipselect`. Read latency is 1 cycle. A read and a write in the same cycle return the pre-write value.
- Output: `out_port = data | pulse_mask`. It is combinational from registers only, so a write is visible the cycle after its edge.
- Pulse state machine (IDLE, PULSING):
  - `eff_len` = `pulse_len`, except `pulse_len` == 0 gives `eff_len` = 1.
  - IDLE, PULSE write with `wd` ≠ 0: `pulse_mask <= wd`, `count <= eff_len - 1`, go to PULSING.
  - IDLE, PULSE write with `wd` == 0: ignored, stay in IDLE.
  - PULSING, `count` ≠ 0, no PULSE write: `count <= count - 1`.
  - PULSING, `count` == 0, no PULSE write: `pulse_mask <= 0`, go to IDLE.
  - PULSING, PULSE write with `wd` ≠ 0 (retrigger): `pulse_mask <= pulse_mask | wd`, `count <= eff_len - 1`, stay in PULSING. The retrigger takes priority over expiry in the same cycle.
  - Net effect: pulsed bits are high for exactly `eff_len` cycles after the last retrigger write.
- Interactions:
  - DATA/SET/CLEAR writes never affect `pulse_mask`. A pulsed bit that is also set in `data` stays high after the pulse expires.
  - A PULSE_LEN write during PULSING affects only later triggers; the running `count` is untouched.
  - Reset mid-pulse: `out_port` returns to RESET_VALUE immediately, asynchronously.
- Width rules: `count` never underflows, because expiry happens at 0. Upper writedata bits are discarded.

Test Plan:
- Reset and read-back:
  - Stimulus: assert `reset_n` = 0 mid-run with RESET_VALUE = 8'hA5, release, then read address 0.
  - Required: `out_port` = A5 during and after reset; `readdata` = 0 during reset, then 0x000000A5 one cycle after the read address is presented.
- Set/clear:
  - Stimulus: write DATA = 0x0F, SET 0xF0, CLEAR 0x3C.
  - Required: `out_port` sequence 0F → FF → C3, each change one cycle after its write edge; a DATA read returns 0xC3.
- Pulse timing:
  - Stimulus: `pulse_len` = 3; PULSE 0x01 with `data` = 0.
  - Required: `out_port[0]` high for exactly 3 cycles; STATUS bit0 = 1 during the pulse, then 0; a read of address 4 returns 0 afterwards.
- Retrigger:
  - Stimulus: `pulse_len` = 4; PULSE 0x01; 2 cycles later PULSE 0x02.
  - Required: bit0 high for 6 cycles total; bit1 high for 4 cycles; both drop on the same cycle.
- Zero-length and expiry-collision cases:
  - Stimulus A: `pulse_len` = 0, then PULSE 0x80.
  - Required A: bit7 high for 1 cycle; STATUS bit1 = 1.
  - Stimulus B: a PULSE write landing exactly on the `count` == 0 cycle.
  - Required B: the retrigger wins and the pulse is extended by `eff_len`.
- Overlap with DATA:
  - Stimulus: `data` = 0x01, PULSE 0x01 with length 2; and separately a reset asserted mid-pulse.
  - Required: bit0 stays high after expiry (comes from `data`); the mid-pulse reset clears `pulse_mask` and STATUS immediately.
